// File: rtl/tm1637_rx.sv
// Responder for the two-wire TM1637-style bus: synchronises and filters SCL/SDA,
// detects START/STOP, deserialises LSB-first bytes and drives the 9th-clock ACK.
`timescale 1ns/1ps
module tm1637_rx #(
    parameter int FILTER_LEN = 3,
    parameter bit ACK_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_en,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       start_det,
    output logic       stop_det,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, BIT, ACK_WAIT, ACK_HI, ACK_END} state_t;

    localparam logic [3:0] FL_M1 = 4'(FILTER_LEN - 1);

    logic [1:0]      scl_sync_q, sda_sync_q;
    logic [1:0]      line_s;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][3:0] fcnt_q, fcnt_d;

    state_t     state_q, state_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       first_q, first_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       en_q, en_d;

    logic scl_prev, scl_cur, sda_prev, sda_cur;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    // Index 1 = SCL, index 0 = SDA
    assign line_s = {scl_sync_q[1], sda_sync_q[1]};

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (line_s[i] == filt_q[i]) begin
                fcnt_d[i] = 4'd0;
            end else if (fcnt_q[i] == FL_M1) begin
                filt_d[i] = line_s[i];
                fcnt_d[i] = 4'd0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 4'd1;
            end
        end
    end

    // Edges compare the registered filter value with the one about to load,
    // so an event registers on the same clock the filter flips.
    assign scl_prev = filt_q[1];
    assign scl_cur  = filt_d[1];
    assign sda_prev = filt_q[0];
    assign sda_cur  = filt_d[0];
    assign scl_rise = !scl_prev && scl_cur;
    assign scl_fall = scl_prev && !scl_cur;
    assign start_ev = scl_prev && scl_cur && sda_prev && !sda_cur;
    assign stop_ev  = scl_prev && scl_cur && !sda_prev && sda_cur;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        first_d    = first_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        ferr_d     = 1'b0;
        busy_d     = busy_q;
        en_d       = en_q;
        if (start_ev) begin
            en_d    = 1'b0;
            bcnt_d  = 3'd0;
            first_d = 1'b1;
            start_d = 1'b1;
            busy_d  = 1'b1;
            ferr_d  = (state_q == BIT) && (bcnt_q != 3'd0);
            state_d = BIT;
        end else if (stop_ev) begin
            en_d    = 1'b0;
            stop_d  = 1'b1;
            busy_d  = 1'b0;
            ferr_d  = (state_q == BIT) && (bcnt_q != 3'd0);
            state_d = IDLE;
        end else begin
            case (state_q)
                BIT: if (scl_rise) begin
                    shift_d[bcnt_q] = sda_prev;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        state_d    = ACK_WAIT;
                    end
                end
                ACK_WAIT: if (scl_fall) begin
                    en_d    = ACK_ENABLE;
                    state_d = ACK_HI;
                end
                ACK_HI: if (scl_rise) state_d = ACK_END;
                ACK_END: if (scl_fall) begin
                    en_d    = 1'b0;
                    bcnt_d  = 3'd0;
                    state_d = BIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            bcnt_q     <= 3'd0;
            shift_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            first_q    <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            first_q    <= first_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
        end
    end

    assign sda_en    = en_q;
    assign sda_out   = 1'b0;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_tm1637_rx.sv
// Directed bench for tm1637_rx: a table of bus transactions plus hand-written
// glitch, ACK-disabled and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_tm1637_rx;
    localparam int H = 12;  // bus half-phase in clocks, well above filter latency

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m_scl = 1'b1, m_sda = 1'b1;
    logic sda_bus, sda_bus0;

    logic       sda_en, sda_out, rx_valid, rx_first, start_det, stop_det, frame_err, busy;
    logic [7:0] rx_data;
    logic       sda_en0, sda_out0, rx_valid0, rx_first0, start_det0, stop_det0, frame_err0, busy0;
    logic [7:0] rx_data0;

    always #5 clk = ~clk;

    // Open-drain bus: each responder sees the master level ANDed with its own pull-down
    assign sda_bus  = m_sda & ~sda_en;
    assign sda_bus0 = m_sda & ~sda_en0;

    tm1637_rx #(.FILTER_LEN(3), .ACK_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst), .scl_in(m_scl), .sda_in(sda_bus),
        .sda_en(sda_en), .sda_out(sda_out), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_first(rx_first), .start_det(start_det), .stop_det(stop_det),
        .frame_err(frame_err), .busy(busy));

    tm1637_rx #(.FILTER_LEN(3), .ACK_ENABLE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .scl_in(m_scl), .sda_in(sda_bus0),
        .sda_en(sda_en0), .sda_out(sda_out0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_first(rx_first0), .start_det(start_det0), .stop_det(stop_det0),
        .frame_err(frame_err0), .busy(busy0));

    int n_start = 0, n_stop = 0, n_valid = 0, n_ferr = 0, n_ferr_stop = 0, n_en = 0;
    int n_valid0 = 0, n_en0 = 0;
    logic [7:0] last_data = 8'd0, last_data0 = 8'd0;
    logic       last_first = 1'b0;

    always @(negedge clk) begin
        if (start_det) n_start <= n_start + 1;
        if (stop_det)  n_stop  <= n_stop + 1;
        if (frame_err) n_ferr  <= n_ferr + 1;
        if (frame_err && stop_det) n_ferr_stop <= n_ferr_stop + 1;
        if (sda_en) n_en <= n_en + 1;
        if (rx_valid) begin
            n_valid    <= n_valid + 1;
            last_data  <= rx_data;
            last_first <= rx_first;
        end
        if (sda_en0) n_en0 <= n_en0 + 1;
        if (rx_valid0) begin
            n_valid0   <= n_valid0 + 1;
            last_data0 <= rx_data0;
        end
    end

    int n_vec = 0, n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        m_scl = 1'b1; m_sda = 1'b1; wt(H);
        m_sda = 1'b0; wt(H);
        m_scl = 1'b0; wt(H);
    endtask

    task automatic do_stop();
        m_sda = 1'b0; wt(H);
        m_scl = 1'b1; wt(H);
        m_sda = 1'b1; wt(H);
    endtask

    // glitch > 0 drops SCL for that many clocks in the middle of the high phase
    task automatic send_bit(input logic b, input int glitch);
        m_sda = b; wt(H);
        m_scl = 1'b1; wt(H);
        if (glitch > 0) begin
            m_scl = 1'b0; wt(glitch);
            m_scl = 1'b1; wt(H);
        end
        m_scl = 1'b0; wt(H);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0);
    endtask

    task automatic ninth();
        m_sda = 1'b1; wt(H);
        chk("ack_after_8th_fall", sda_en, 1);
        m_scl = 1'b1; wt(H);
        m_scl = 1'b0; wt(H);
        chk("ack_released", sda_en, 0);
    endtask

    typedef struct {
        bit         start;
        int         nbits;
        logic [7:0] data;
        bit         stop;
        bit         exp_valid;
        bit         exp_first;
        bit         exp_ferr_start;
        bit         exp_ferr_stop;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int s0, p0, v0, f0, fs0, e0, e00, v00;
        logic [14:0] outs;

        // Any STOP after a full byte raises SCL once more in BIT (phantom bit 0),
        // so it is expected to flag frame_err; a repeated START does the same.
        tbl[0] = '{1'b1, 8, 8'h40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 8, 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 4, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 3, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        wt(5);
        outs = {sda_en, sda_out, rx_data, rx_valid, rx_first, start_det, stop_det, frame_err, busy};
        chk("reset_outputs", outs, 15'd0);
        rst = 1'b1;
        wt(20);
        chk("no_pulses_after_reset", n_start + n_stop + n_valid + n_ferr + n_en, 0);

        for (int i = 0; i < 7; i++) begin
            s0 = n_start; p0 = n_stop; v0 = n_valid; f0 = n_ferr; fs0 = n_ferr_stop;
            if (tbl[i].start) begin
                do_start();
                chk($sformatf("v%0d_start_det", i), n_start - s0, 1);
                chk($sformatf("v%0d_busy_set", i), busy, 1);
                chk($sformatf("v%0d_ferr_at_start", i), n_ferr - f0, tbl[i].exp_ferr_start);
            end
            f0 = n_ferr; e0 = n_en;
            for (int b = 0; b < tbl[i].nbits; b++) send_bit(tbl[i].data[b], 0);
            if (tbl[i].nbits == 8) begin
                ninth();
                chk($sformatf("v%0d_ack_width", i), n_en - e0, 3 * H);
            end else begin
                chk($sformatf("v%0d_no_ack", i), n_en - e0, 0);
            end
            chk($sformatf("v%0d_valid_cnt", i), n_valid - v0, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("v%0d_data", i), last_data, tbl[i].data);
                chk($sformatf("v%0d_first", i), last_first, tbl[i].exp_first);
            end
            chk($sformatf("v%0d_ferr_mid", i), n_ferr - f0, 0);
            if (tbl[i].stop) begin
                do_stop();
                chk($sformatf("v%0d_stop_det", i), n_stop - p0, 1);
                chk($sformatf("v%0d_ferr_with_stop", i), n_ferr_stop - fs0, tbl[i].exp_ferr_stop);
                chk($sformatf("v%0d_ferr_total", i), n_ferr - f0, tbl[i].exp_ferr_stop);
                chk($sformatf("v%0d_busy_clr", i), busy, 0);
            end
        end

        // 2-clock SCL glitch is filtered out: byte reads 0x01
        v0 = n_valid;
        do_start();
        send_bit(1'b1, 2);
        for (int b = 1; b < 8; b++) send_bit(1'b0, 0);
        ninth();
        chk("glitch2_valid_cnt", n_valid - v0, 1);
        chk("glitch2_data", last_data, 8'h01);
        do_stop();

        // 3-clock glitch passes the filter and counts as an extra clock: 0x03 after 7 pulses
        v0 = n_valid;
        do_start();
        send_bit(1'b1, 3);
        for (int b = 2; b < 8; b++) send_bit(1'b0, 0);
        ninth();
        chk("glitch3_valid_cnt", n_valid - v0, 1);
        chk("glitch3_data", last_data, 8'h03);
        do_stop();

        // ACK disabled instance: byte received, SDA never driven
        v00 = n_valid0; e00 = n_en0;
        do_start();
        send_byte(8'hA5);
        ninth();
        chk("noack_valid_cnt", n_valid0 - v00, 1);
        chk("noack_data", last_data0, 8'hA5);
        chk("noack_sda_en", n_en0 - e00, 0);

        // Reset during bit 5 of the next byte
        for (int b = 0; b < 5; b++) send_bit(1'b0, 0);
        m_sda = 1'b1; wt(H);
        m_scl = 1'b1; wt(H / 2);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        outs = {sda_en, sda_out, rx_data, rx_valid, rx_first, start_det, stop_det, frame_err, busy};
        chk("midbyte_reset_outputs", outs, 15'd0);
        chk("midbyte_reset_busy0", busy0, 0);
        m_scl = 1'b1; m_sda = 1'b1;
        wt(5);
        rst = 1'b1;
        wt(20);

        // Reset while our ACK is being driven releases SDA at once
        do_start();
        send_byte(8'h5A);
        m_sda = 1'b1; wt(H);
        chk("ack_before_reset", sda_en, 1);
        rst = 1'b0;
        #1;
        chk("ack_async_release", sda_en, 0);
        m_scl = 1'b1; m_sda = 1'b1;
        wt(5);
        rst = 1'b1;
        wt(20);

        // Clean byte after reset: earlier partial byte leaves no trace
        v0 = n_valid;
        do_start();
        send_byte(8'h5A);
        ninth();
        chk("post_reset_valid_cnt", n_valid - v0, 1);
        chk("post_reset_data", last_data, 8'h5A);
        chk("post_reset_first", last_first, 1);
        do_stop();
        chk("post_reset_busy_clr", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
